// File: rtl/mem_ctrl_pkg.sv
// Shared types and op decoding for the data-SRAM initiator and the DF-side load extractor.
// Pure declarations: no latency or backpressure of its own.
package mem_ctrl_pkg;

    localparam int ALU_OP_W   = 8;
    localparam int WAIT_CNT_W = 4;

    localparam logic        STOP      = 1'b1;
    localparam logic        BE_ACT    = 1'b1;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t OP_NOP = 8'h00;
    localparam alu_op_t OP_ADD = 8'h01;
    localparam alu_op_t OP_LB  = 8'h20;
    localparam alu_op_t OP_LBU = 8'h21;
    localparam alu_op_t OP_LH  = 8'h22;
    localparam alu_op_t OP_LHU = 8'h23;
    localparam alu_op_t OP_LW  = 8'h24;
    localparam alu_op_t OP_SB  = 8'h28;
    localparam alu_op_t OP_SH  = 8'h29;
    localparam alu_op_t OP_SW  = 8'h2A;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {BYTE, HALF, WORD} size_t;

    function automatic logic is_load(input alu_op_t op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_store(input alu_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic size_t op_size(input alu_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return BYTE;
            OP_LH, OP_LHU, OP_SH: return HALF;
            default:              return WORD;
        endcase
    endfunction

endpackage

// File: rtl/data_sram_ctrl_if.sv
// External asynchronous SRAM bus; all strobes active-low.
// master drives address/data/strobes, slave returns read data.
interface data_sram_ctrl_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic [31:0]       SRAM_WDATA;
    logic [31:0]       SRAM_RDATA;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;
    logic              SRAM_WE_N;
    logic [3:0]        SRAM_BE_N;

    modport master (
        output SRAM_ADDR, SRAM_WDATA, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_BE_N,
        input  SRAM_RDATA
    );

    modport slave (
        input  SRAM_ADDR, SRAM_WDATA, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_BE_N,
        output SRAM_RDATA
    );
endinterface

// File: rtl/sram_lane_gen.sv
// Byte-lane enables, lane-replicated store data and misalignment flag for one op.
// Purely combinational, no backpressure.
module sram_lane_gen
    import mem_ctrl_pkg::*;
(
    input  alu_op_t     op,
    input  logic [1:0]  addr,
    input  logic [31:0] rt,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign
);

    always_comb begin
        be       = 4'b0000;
        wdata    = rt;
        misalign = 1'b0;
        if (is_load(op) || is_store(op)) begin
            case (op_size(op))
                BYTE: begin
                    be    = 4'b0001 << addr;
                    wdata = {4{rt[7:0]}};
                end
                HALF: begin
                    be       = 4'b0011 << addr;
                    wdata    = {2{rt[15:0]}};
                    misalign = addr[0];
                end
                default: begin
                    be       = 4'b1111;
                    wdata    = rt;
                    misalign = |addr;
                end
            endcase
        end
    end

endmodule

// File: rtl/data_sram_ctrl.sv
// EX-side initiator for the async data SRAM: op in cycle 0, DONE in cycle WAIT_CYCLES+2.
// STALL_REQ holds EX for the access; STALL_IN parks the FSM in DONE with outputs held.
module data_sram_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 20
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  alu_op_t               EX_ALU_OP,
    input  logic [31:0]           EX_MEM_ADDR,
    input  logic [31:0]           EX_STORE_DATA,
    input  logic                  STALL_IN,
    output logic                  STALL_REQ,
    output logic                  ADDR_ERR_L,
    output logic                  ADDR_ERR_S,
    data_sram_ctrl_if.master      sram,
    output logic [3:0]            DF_SRAM_DATA_BE,
    output logic [31:0]           DF_SRAM_RDATA
);

    state_t                state;
    logic [WAIT_CNT_W-1:0] cnt;
    logic [3:0]            be_r;
    logic                  load_r;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        misalign;
    logic        op_ld;
    logic        op_st;
    logic        start;
    logic        unused_addr_hi;

    sram_lane_gen u_lane_gen (
        .op       (EX_ALU_OP),
        .addr     (EX_MEM_ADDR[1:0]),
        .rt       (EX_STORE_DATA),
        .be       (lane_be),
        .wdata    (lane_wdata),
        .misalign (misalign)
    );

    assign op_ld          = is_load(EX_ALU_OP);
    assign op_st          = is_store(EX_ALU_OP);
    assign start          = (state == IDLE) && (op_ld || op_st) && !misalign;
    assign unused_addr_hi = ^EX_MEM_ADDR[31:ADDR_W+2];

    // In DONE the EX bus still carries the finished op, so errors only fire in IDLE.
    assign ADDR_ERR_L = (state == IDLE) && op_ld && misalign;
    assign ADDR_ERR_S = (state == IDLE) && op_st && misalign;
    assign STALL_REQ  = (start || state == ACCESS) ? STOP : ~STOP;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            cnt             <= '0;
            be_r            <= 4'b0000;
            load_r          <= 1'b0;
            sram.SRAM_ADDR  <= '0;
            sram.SRAM_WDATA <= ZERO_WORD;
            sram.SRAM_CE_N  <= 1'b1;
            sram.SRAM_OE_N  <= 1'b1;
            sram.SRAM_WE_N  <= 1'b1;
            sram.SRAM_BE_N  <= 4'hF;
            DF_SRAM_DATA_BE <= {4{~BE_ACT}};
            DF_SRAM_RDATA   <= ZERO_WORD;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= ACCESS;
                        cnt             <= WAIT_CNT_W'(WAIT_CYCLES);
                        be_r            <= lane_be;
                        load_r          <= op_ld;
                        sram.SRAM_ADDR  <= EX_MEM_ADDR[ADDR_W+1:2];
                        sram.SRAM_WDATA <= lane_wdata;
                        sram.SRAM_CE_N  <= 1'b0;
                        sram.SRAM_OE_N  <= ~op_ld;
                        sram.SRAM_WE_N  <= ~op_st;
                        sram.SRAM_BE_N  <= ~lane_be;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state           <= DONE;
                        sram.SRAM_CE_N  <= 1'b1;
                        sram.SRAM_OE_N  <= 1'b1;
                        sram.SRAM_WE_N  <= 1'b1;
                        sram.SRAM_BE_N  <= 4'hF;
                        DF_SRAM_DATA_BE <= be_r ^ {4{~BE_ACT}};
                        if (load_r) begin
                            DF_SRAM_RDATA <= sram.SRAM_RDATA;
                        end
                    end else begin
                        cnt <= cnt - WAIT_CNT_W'(1);
                        // Write strobe rises one cycle early so address/data hold past WE_N.
                        if (cnt == WAIT_CNT_W'(1)) begin
                            sram.SRAM_WE_N <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (STALL_IN != STOP) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_sram_ctrl.md
Name: data_sram_ctrl

Overview:
- Initiator side of the data-SRAM interface. It takes a load or store from the EX stage and drives an asynchronous, active-low external SRAM through a wait-stated access FSM.
- It stalls the pipeline while an access is in flight. It then hands the captured read word and byte-select to the DF/MEM pipeline register.
- It sits between EX and the DF/MEM register.

Parameters:
- WAIT_CYCLES, default 1: number of SRAM strobe cycles per access. Legal range 1..15.
- ADDR_W, default 20: width of the SRAM word address.

Ports:
- CLK  in  1  clock
- RST  in  1  reset. Synchronous, active-high (`RST_EN).
- EX_ALU_OP  in  `ALU_OP_BUS  op from EX. Only LB/LBU/LH/LHU/LW/SB/SH/SW act.
- EX_MEM_ADDR  in  32  byte address.
- EX_STORE_DATA  in  32  raw rt value.
- STALL_IN  in  1  downstream stall (`STOP). Holds the DONE state.
- STALL_REQ  out  1  request pipeline stall (`STOP).
- ADDR_ERR_L  out  1  misaligned load. Combinational, same cycle as the op.
- ADDR_ERR_S  out  1  misaligned store. Combinational, same cycle as the op.
- SRAM_ADDR  out  ADDR_W  word address, EX_MEM_ADDR[ADDR_W+1:2].
- SRAM_WDATA  out  32  lane-replicated store data.
- SRAM_RDATA  in  32  SRAM read data.
- SRAM_CE_N  out  1  chip enable, active-low.
- SRAM_OE_N  out  1  output enable, active-low.
- SRAM_WE_N  out  1  write enable, active-low.
- SRAM_BE_N  out  4  byte enables, active-low.
- DF_SRAM_DATA_BE  out  `SRAM_BSEL_BUS  byte-select of the completed access, `BE polarity.
- DF_SRAM_RDATA  out  `SRAM_DATA_BUS  registered read word.

Behaviour:
- Reset:
  - State = IDLE, counter = 0.
  - SRAM_CE_N, SRAM_OE_N, SRAM_WE_N = 1. SRAM_BE_N = 4'hF.
  - SRAM_ADDR = 0, SRAM_WDATA = 0.
  - DF_SRAM_DATA_BE = ~`BE on all bits. DF_SRAM_RDATA = `ZERO_WORD.
  - STALL_REQ = ~`STOP.
  - RST mid-access aborts at the next edge. The strobes are high on the following cycle; no completion is reported.
- Lane generation (combinational, from EX_MEM_ADDR[1:0]):
  - Byte ops: BE = 4'b0001 << a. Data = {4{rt[7:0]}}.
  - Half ops: BE = 4'b0011 << a, requires a[0] = 0. Data = {2{rt[15:0]}}.
  - Word ops: BE = 4'b1111, requires a = 0. Data = rt.
- Misalignment:
  - Raise ADDR_ERR_L or ADDR_ERR_S for that cycle.
  - No access is started and STALL_REQ stays deasserted.
  - The FSM stays in IDLE.
- IDLE:
  - A valid aligned memory op raises STALL_REQ combinationally.
  - Next edge: register address, data and BE; load counter = WAIT_CYCLES; go to ACCESS.
  - Non-memory ops: no action.
- ACCESS (WAIT_CYCLES+1 cycles):
  - CE_N = 0 and BE_N = ~BE throughout. Address and data are stable throughout.
  - Loads: OE_N = 0 for all ACCESS cycles.
  - Stores: WE_N = 0 for the first WAIT_CYCLES cycles, then 1 on the final cycle (data/address hold).
  - Counter decrements each cycle.
  - On the edge ending the final cycle (counter == 0): loads capture SRAM_RDATA into DF_SRAM_RDATA; DF_SRAM_DATA_BE = BE; go to DONE.
  - STALL_REQ is asserted for the whole of ACCESS.
- DONE:
  - All strobes high. STALL_REQ deasserted so the pipeline advances.
  - EX inputs are ignored this cycle; they still carry the old op.
  - If STALL_IN == `STOP, remain in DONE with outputs held.
  - Otherwise go to IDLE at the next edge.
- Latency:
  - Op seen in cycle 0; DONE in cycle WAIT_CYCLES+2.
  - STALL_REQ is high for cycles 0..WAIT_CYCLES+1.
- Back-to-back memory ops: each pays the full latency. The second op is accepted in IDLE in the cycle after DONE.
- Store completion leaves DF_SRAM_RDATA unchanged but updates DF_SRAM_DATA_BE.

Decomposition:
- mem_ctrl_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - function is_load(op) and function is_store(op);
  - function op_size(op) returning {BYTE, HALF, WORD};
  - WAIT_CNT_W = 4.
- One combinational sub-module, sram_lane_gen. It takes op and addr[1:0] plus rt, and outputs BE, replicated write data and a misalign flag. It is reused by the DF-side load extractor.

Test Plan:
- LW addr 0x0000_0010, WAIT_CYCLES=1, SRAM_RDATA=0xDEADBEEF:
  - SRAM_ADDR=0x4, BE_N=0x0, OE_N low for 2 cycles.
  - STALL_REQ high for 3 cycles.
  - Then DF_SRAM_RDATA=0xDEADBEEF, DF_SRAM_DATA_BE=4'b1111.
- SB addr 0x0000_0003, rt=0x123456AB:
  - SRAM_WDATA=0xABABABAB, BE_N=4'b0111.
  - WE_N low 1 cycle then high 1 cycle with the address held.
  - DF_SRAM_DATA_BE=4'b1000.
- LH addr 0x0000_0001: ADDR_ERR_L=1 that cycle; STALL_REQ never asserted; CE_N stays 1.
- SW addr 0x2 gives ADDR_ERR_S=1. SH addr 0x2, rt=0x0000BEEF gives WDATA=0xBEEFBEEF, BE_N=4'b0011.
- LW with STALL_IN=`STOP for 3 cycles at DONE: FSM stays in DONE and outputs stay stable. Release returns to IDLE. A following LBU is then accepted.
- RST pulsed in the second ACCESS cycle of a SW: next cycle CE_N, WE_N = 1, BE_N = 0xF, STALL_REQ deasserted, DF outputs back at reset values.
